// File: rtl/rv32i_types.sv
// Shared RV32 types: the M-extension multiply funct3 encodings.
package rv32i_types;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    mul    = 3'b000,
    mulh   = 3'b001,
    mulhsu = 3'b010,
    mulhu  = 3'b011
  } m_funct3_t;
endpackage

// File: rtl/mul_unit_array.sv
// Unsigned W x W -> 2W combinational array multiplier (shifted partial-product rows).
module mul_unit_array #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] f
);
  logic [W-1:0][2*W-1:0] w_pp;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_row
      assign w_pp[gi] = b[gi] ? ({{W{1'b0}}, a} << gi) : '0;
    end
  endgenerate

  always_comb begin
    f = '0;
    for (int i = 0; i < W; i++) f = f + w_pp[i];
  end
endmodule

// File: rtl/mul_unit.sv
// RV32M multiply unit: IDLE -> PREP (magnitudes) -> MUL (unsigned product) -> FIX (sign, half-select).
module mul_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, PREP, MUL, FIX} state_e;

  state_e      r_state, w_next;
  m_funct3_t   r_op;
  logic [31:0] r_a, r_b, r_mag_a, r_mag_b, r_result;
  logic        r_neg, r_done;
  logic [63:0] r_prod, w_prod, w_prod_fix;
  logic        w_accept, w_sa, w_sb;
  logic [31:0] w_mag_a, w_mag_b, w_sel;

  assign w_accept = (r_state == IDLE) && start && !flush && !funct3[2];

  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = PREP;
        PREP:    w_next = MUL;
        MUL:     w_next = FIX;
        FIX:     w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // MUL and MULHU see both operands as unsigned; 0x80000000 negates to itself.
  assign w_sa    = ((r_op == mulh) || (r_op == mulhsu)) && r_a[31];
  assign w_sb    = (r_op == mulh) && r_b[31];
  assign w_mag_a = w_sa ? (~r_a + 32'd1) : r_a;
  assign w_mag_b = w_sb ? (~r_b + 32'd1) : r_b;

  mul_unit_array #(.W(32)) u_array (
    .a (r_mag_a),
    .b (r_mag_b),
    .f (w_prod)
  );

  assign w_prod_fix = r_neg ? (~r_prod + 64'd1) : r_prod;
  assign w_sel      = (r_op == mul) ? w_prod_fix[31:0] : w_prod_fix[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= mul;
      r_a      <= '0;
      r_b      <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == FIX) && !flush;
      if (w_accept) begin
        r_op <= m_funct3_t'(funct3);
        r_a  <= rs1_data;
        r_b  <= rs2_data;
      end
      if (r_state == PREP && !flush) begin
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_neg   <= w_sa ^ w_sb;
      end
      if (r_state == MUL && !flush) r_prod <= w_prod;
      if (r_state == FIX && !flush) r_result <= w_sel;
    end
  end

  assign ready  = (r_state == IDLE);
  assign done   = r_done;
  assign result = r_result;
endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corners, flush/reset aborts, busy/div ignores, random sweep.
module tb_mul_unit;
  logic        clk, rst_n, start, flush, ready, done;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, result;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  mul_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .ready(ready), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact 64-bit product of the sign/zero-extended operands.
  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int t_acc);
    start = 1'b1; funct3 = op; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int t_done, output bit ok);
    ok = 1'b0; t_done = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; t_done = cyc; break; end
    end
  endtask

  task automatic count_dones(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) c++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 0; flush = 0; funct3 = 0; rs1_data = 0; rs2_data = 0;
    #3 rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0, 3'd2};
    logic [31:0] as  [8] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd0};
    logic [31:0] bs  [8] = '{32'hFFFFFFFD, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] exp [8] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd0};
    int ta, td; bit ok;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i], ta);
      wait_done(td, ok);
      total++; if (!ok || td - ta != 3) $display("FAIL dir%0d_latency got %0d want 3", i, td - ta); else pass_cnt++;
      total++; if (result !== exp[i]) $display("FAIL dir%0d_result got %h want %h", i, result, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_flush;
    int ta, td, c; bit ok; logic [31:0] prior;
    start_op(3'd3, 32'h12345678, 32'h9ABCDEF0, ta);
    wait_done(td, ok);
    prior = golden(3'd3, 32'h12345678, 32'h9ABCDEF0);
    total++; if (!ok || result !== prior) $display("FAIL flush_prior got %h want %h", result, prior); else pass_cnt++;
    start_op(3'd0, 32'd5, 32'd6, ta);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    total++; if (ready !== 1'b1) $display("FAIL flush_ready got %b want 1", ready); else pass_cnt++;
    total++; if (result !== prior) $display("FAIL flush_result got %h want %h", result, prior); else pass_cnt++;
    count_dones(6, c);
    total++; if (c != 0) $display("FAIL flush_nodone got %0d want 0", c); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int ta, c;
    start_op(3'd1, 32'hDEADBEEF, 32'h0BADF00D, ta);
    #2 rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", ready); else pass_cnt++;
    total++; if (result !== 32'd0) $display("FAIL rstmid_result got %h want 0", result); else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    count_dones(6, c);
    total++; if (c != 0 || ready !== 1'b1) $display("FAIL rstmid_nodone got %0d dones ready %b want 0 and 1", c, ready); else pass_cnt++;
  endtask

  task automatic test_busy_ignore;
    int ta, td, c; bit ok; logic [31:0] exp;
    exp = golden(3'd1, 32'hFFFF0001, 32'h00020003);
    start_op(3'd1, 32'hFFFF0001, 32'h00020003, ta);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd11; rs2_data = 32'd13;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(td, ok);
    total++; if (!ok || td - ta != 3) $display("FAIL busy_latency got %0d want 3", td - ta); else pass_cnt++;
    total++; if (result !== exp) $display("FAIL busy_result got %h want %h", result, exp); else pass_cnt++;
    count_dones(5, c);
    total++; if (c != 0) $display("FAIL busy_extra_done got %0d want 0", c); else pass_cnt++;
  endtask

  task automatic test_div_ignore;
    int c; logic [31:0] prior;
    prior = result;
    start = 1'b1; funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    total++; if (ready !== 1'b1) $display("FAIL div_ready got %b want 1", ready); else pass_cnt++;
    count_dones(6, c);
    total++; if (c != 0) $display("FAIL div_nodone got %0d want 0", c); else pass_cnt++;
    total++; if (result !== prior) $display("FAIL div_result got %h want %h", result, prior); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int ta1, td1, ta2, td2; bit ok1, ok2; logic [31:0] e1, e2;
    e1 = golden(3'd2, 32'h87654321, 32'hF0000001);
    e2 = golden(3'd1, 32'h7FFFFFFF, 32'h80000001);
    start_op(3'd2, 32'h87654321, 32'hF0000001, ta1);
    wait_done(td1, ok1);
    total++; if (!ok1 || result !== e1) $display("FAIL b2b_first got %h want %h", result, e1); else pass_cnt++;
    total++; if (ready !== 1'b1) $display("FAIL b2b_ready_in_done got %b want 1", ready); else pass_cnt++;
    start_op(3'd1, 32'h7FFFFFFF, 32'h80000001, ta2);
    wait_done(td2, ok2);
    total++; if (!ok2 || result !== e2) $display("FAIL b2b_second got %h want %h", result, e2); else pass_cnt++;
    // Second start lands on the edge closing the done cycle, so dones are latency+1 edges apart.
    total++; if (!ok2 || td2 - td1 != 4 || td2 - ta2 != 3) $display("FAIL b2b_spacing got %0d/%0d want 4/3", td2 - td1, td2 - ta2); else pass_cnt++;
  endtask

  task automatic test_random;
    int ta, td; bit ok; logic [2:0] op; logic [31:0] a, b, e;
    logic [31:0] corner [4] = '{32'd0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      e  = golden(op, a, b);
      start_op(op, a, b, ta);
      wait_done(td, ok);
      total++;
      if (!ok || td - ta != 3 || result !== e)
        $display("FAIL rand%0d op%0d a=%h b=%h got %h lat %0d want %h lat 3", i, op, a, b, result, td - ta, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_flush;
    test_reset_mid;
    test_busy_ignore;
    test_div_ignore;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
